alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Issuing side of the SAYEH ALU control interface. Accepts an opcode over a valid/ready handshake and
//  drives the ten one-hot ALU select lines plus cin. Holds them for a settle window, then captures
//  aluout/cout/zout into a result register and the C/Z flag register. Returns the result over a
//  second valid/ready handshake. Sits between the controller and the combinational ALU.
// PARAMETERS
//  DATA_W         16  ALU operand/result width.
//  SETTLE_CYCLES  1   Cycles the select lines are held before capture; legal range 1..15.
// PORTS
//  clk           in   1       System clock; all state changes on rising edge.
//  rst_n         in   1       Asynchronous, active-low reset.
//  op_valid      in   1       Opcode request valid.
//  op_ready      out  1       Sequencer idle, can accept a request.
//  opcode        in   4       0 B15to0, 1 AandB, 2 AorB, 3 notB, 4 shlB, 5 shrB, 6 AaddB, 7 AsubB,
//                             8 AmulB, 9 AcmpB, 10-15 undefined.
//  use_carry     in   1       1: cin = C flag at accept; 0: cin = 0.
//  B15to0..AcmpB out  1 each  One-hot ALU selects, same names/order as the ALU inputs.
//  cin           out  1       Carry into ALU.
//  aluout        in   DATA_W  ALU result.
//  cout, zout    in   1       ALU carry / zero outputs.
//  res_valid     out  1       Captured result available.
//  res_ready     in   1       Consumer takes the result.
//  result        out  DATA_W  Captured aluout.
//  c_flag,z_flag out  1       Flag register.
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, all selects 0, cin 0, res_valid 0, result 0, c_flag 0,
//   z_flag 0, settle counter 0. op_ready=1 once in IDLE. Reset mid-operation abandons the op.
//   No capture; flags are cleared.
//  FSM: IDLE -> ISSUE -> CAPTURE -> RESULT -> IDLE.
//  IDLE: op_ready=1. On op_valid&op_ready: register opcode and cin (use_carry ? c_flag : 0).
//   Go to ISSUE.
//  ISSUE: exactly one select line high, per the registered opcode; all others 0.
//   Lines are registered outputs, so they rise the cycle after accept.
//   Held SETTLE_CYCLES cycles (counter), then go to CAPTURE.
//  CAPTURE (1 cycle, selects still driven): result<=aluout.
//   z_flag<=zout for opcodes 0-9.
//   c_flag<=cout only for opcodes 6, 7, 9; otherwise unchanged.
//   Selects and cin return to 0 on the next edge.
//  RESULT: res_valid=1, result stable until res_valid&res_ready, then IDLE.
//   A new op can be accepted no earlier than the cycle after the handshake.
//  Latency accept -> res_valid = SETTLE_CYCLES+2 cycles.
//  Outside ISSUE/CAPTURE all select lines and cin are 0 (ALU default output 0).
//  op_valid while not in IDLE is ignored. opcode/use_carry are sampled only at accept.
//  Flags change only in CAPTURE.
//  SETTLE_CYCLES outside 1..15: treated as 1.
// CONFIGURATION
//  ALU_ILLEGAL_TRAP_EN undefined: opcode 10-15 runs the normal sequence with all selects 0.
//   Captures result=0, z_flag=1, c_flag unchanged.
//  ALU_ILLEGAL_TRAP_EN defined: adds output illegal_op (1 bit, reset 0).
//   Opcode 10-15 skips ISSUE/CAPTURE: IDLE -> RESULT the cycle after accept.
//   result=0, flags unchanged, illegal_op=1 while res_valid.
//   illegal_op=0 for legal ops.
// TESTING
//  T1 reset: rst_n=0 mid-ISSUE of opcode 6 -> selects/cin/res_valid/flags 0 immediately.
//   op_ready=1 after release.
//  T2 add with carry: c_flag=1, opcode 6, use_carry=1, ALU model A=0xFFFF, B=0x0000.
//   -> AaddB only during ISSUE, cin=1, result 0x0000, c_flag=1, z_flag=1, latency 3 (SETTLE=1).
//  T3 compare: opcode 9, A=0x0005, B=0x0003 -> result 0x0005, c_flag=1, z_flag=0.
//   Then opcode 1 (AND -> 0x0001) -> c_flag stays 1.
//  T4 backpressure: res_ready=0 for 5 cycles -> res_valid and result held.
//   op_valid pulses ignored; op_ready=0 throughout.
//  T5 SETTLE_CYCLES=4, opcode 8 -> AmulB high exactly 5 cycles (4 settle + capture).
//   res_valid 6 cycles after accept.
//  T6 opcode 12: without macro -> no select high, result 0, z_flag=1.
//   With ALU_ILLEGAL_TRAP_EN -> res_valid 1 cycle after accept, illegal_op=1, flags unchanged.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - Opcode issue, settle and capture sequencer for the SAYEH ALU
//
// Purpose:
//   Takes one opcode at a time from the controller over a valid/ready handshake.
//   It raises the matching one-hot ALU select line and cin, and holds them while
//   the combinational ALU settles. It then captures aluout/cout/zout into the
//   result and C/Z flag registers, and returns the result over a second
//   valid/ready handshake.
//
// Optional feature macro: ALU_ILLEGAL_TRAP_EN
//   undefined : opcodes 10-15 run the normal sequence with every select low,
//               capture result=0, z_flag=1, c_flag unchanged.
//   defined   : adds output illegal_op. Opcodes 10-15 jump straight from IDLE
//               to RESULT with result=0 and unchanged flags. illegal_op is high
//               while that result is offered.
//
// Parameters:
//   DATA_W         ALU operand/result width (default 16)
//   SETTLE_CYCLES  cycles selects are held before capture, 1..15; any other
//                  value behaves as 1
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   op_valid, op_ready         opcode request handshake
//   opcode[3:0], use_carry     request payload, sampled only at accept
//   B15to0 .. AcmpB            one-hot ALU select lines (registered)
//   cin                        carry into ALU (registered)
//   aluout, cout, zout         combinational ALU outputs
//   res_valid, res_ready       result handshake
//   result                     captured aluout
//   c_flag, z_flag             flag register
//   illegal_op                 (ALU_ILLEGAL_TRAP_EN only) trapped-opcode marker

module alu_op_sequencer #(
  parameter int DATA_W        = 16,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        opcode,
  input  logic              use_carry,
  output logic              B15to0,
  output logic              AandB,
  output logic              AorB,
  output logic              notB,
  output logic              shlB,
  output logic              shrB,
  output logic              AaddB,
  output logic              AsubB,
  output logic              AmulB,
  output logic              AcmpB,
  output logic              cin,
  input  logic [DATA_W-1:0] aluout,
  input  logic              cout,
  input  logic              zout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] result,
  output logic              c_flag,
  output logic              z_flag
`ifdef ALU_ILLEGAL_TRAP_EN
  ,
  output logic              illegal_op
`endif
);

  // Out-of-range settle values fall back to a single settle cycle.
  localparam int         SETTLE_EFF  = ((SETTLE_CYCLES >= 1) && (SETTLE_CYCLES <= 15)) ?
                                       SETTLE_CYCLES : 1;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESULT  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_op;
  logic [3:0]          r_cnt;
  logic [9:0]          r_sel;
  logic                r_cin;
  logic [DATA_W-1:0]   r_result;
  logic                r_c;
  logic                r_z;

  logic                w_accept;
  logic                w_in_legal;
  logic                w_op_legal;
  logic                w_carry_op;
  logic                w_settle_done;
  logic [9:0]          w_onehot;
  logic                w_op_ready;
  logic                w_res_valid;

  // Select bit i corresponds to opcode i, in ALU port order.
  assign {AcmpB, AmulB, AsubB, AaddB, shrB, shlB, notB, AorB, AandB, B15to0} = r_sel;
  assign cin    = r_cin;
  assign result = r_result;
  assign c_flag = r_c;
  assign z_flag = r_z;

  assign op_ready  = w_op_ready;
  assign res_valid = w_res_valid;

  assign w_accept      = w_op_ready & op_valid;
  assign w_in_legal    = (opcode <= 4'd9);
  assign w_op_legal    = (r_op <= 4'd9);
  // Only add, subtract and compare produce a carry worth keeping.
  assign w_carry_op    = (r_op == 4'd6) || (r_op == 4'd7) || (r_op == 4'd9);
  assign w_settle_done = (r_cnt == SETTLE_LAST);
  assign w_onehot      = w_in_legal ? (10'd1 << opcode) : 10'd0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_op_ready  = 1'b0;
    w_res_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_op_ready = 1'b1;
        if (op_valid) begin
`ifdef ALU_ILLEGAL_TRAP_EN
          w_state_nxt = w_in_legal ? ST_ISSUE : ST_RESULT;
`else
          w_state_nxt = ST_ISSUE;
`endif
        end
      end
      ST_ISSUE: begin
        if (w_settle_done) begin
          w_state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        w_state_nxt = ST_RESULT;
      end
      ST_RESULT: begin
        w_res_valid = 1'b1;
        if (res_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath: opcode/cin capture at accept, settle counter, result/flag capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= 4'd0;
      r_cnt    <= 4'd0;
      r_sel    <= 10'd0;
      r_cin    <= 1'b0;
      r_result <= '0;
      r_c      <= 1'b0;
      r_z      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= opcode;
        r_cnt <= 4'd0;
`ifdef ALU_ILLEGAL_TRAP_EN
        // A trapped opcode never drives the ALU; its result is a fixed zero.
        if (w_in_legal) begin
          r_sel <= w_onehot;
          r_cin <= use_carry & r_c;
        end else begin
          r_result <= '0;
        end
`else
        r_sel <= w_onehot;
        r_cin <= use_carry & r_c;
`endif
      end

      if (r_state == ST_ISSUE) begin
        r_cnt <= w_settle_done ? 4'd0 : (r_cnt + 4'd1);
      end

      // Selects stay driven through the capture cycle and drop on its edge.
      if (r_state == ST_CAPTURE) begin
        r_sel <= 10'd0;
        r_cin <= 1'b0;
        if (w_op_legal) begin
          r_result <= aluout;
          r_z      <= zout;
          if (w_carry_op) begin
            r_c <= cout;
          end
        end else begin
          r_result <= '0;
          r_z      <= 1'b1;
        end
      end
    end
  end

`ifdef ALU_ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_illegal <= ~w_in_legal;
    end else if (w_res_valid && res_ready) begin
      r_illegal <= 1'b0;
    end
  end

  assign illegal_op = r_illegal;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - Scoreboard bench for alu_op_sequencer with an ALU model
module tb_alu_op_sequencer;

  localparam int DW = 16;
  localparam int S  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          op_valid;
  logic          op_ready;
  logic [3:0]    opcode;
  logic          use_carry;
  logic          B15to0, AandB, AorB, notB, shlB, shrB, AaddB, AsubB, AmulB, AcmpB;
  logic          cin;
  logic [DW-1:0] aluout;
  logic          cout;
  logic          zout;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] result;
  logic          c_flag;
  logic          z_flag;
`ifdef ALU_ILLEGAL_TRAP_EN
  logic          illegal_op;
`endif

  logic [15:0]   opA;
  logic [15:0]   opB;
  logic [9:0]    sel;

  always #5 clk = ~clk;

  assign sel = {AcmpB, AmulB, AsubB, AaddB, shrB, shlB, notB, AorB, AandB, B15to0};

  alu_op_sequencer #(.DATA_W(DW), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode), .use_carry(use_carry),
    .B15to0(B15to0), .AandB(AandB), .AorB(AorB), .notB(notB), .shlB(shlB),
    .shrB(shrB), .AaddB(AaddB), .AsubB(AsubB), .AmulB(AmulB), .AcmpB(AcmpB),
    .cin(cin), .aluout(aluout), .cout(cout), .zout(zout),
    .res_valid(res_valid), .res_ready(res_ready), .result(result),
    .c_flag(c_flag), .z_flag(z_flag)
`ifdef ALU_ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  typedef struct {
    logic [3:0]  op;
    logic        cin;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        ill;
    int          lat;
    int          selc;
    logic [9:0]  onehot;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   m_c, m_z;
  bit   mon_en = 1'b0;
  int   done_cnt = 0;
  int   stall_req = 0;

  // Behavioural ALU: returns {cout, zout, out}. Opcodes outside 0-9 mean "no select".
  function automatic logic [17:0] alu_ref(input int op, input logic [15:0] a, input logic [15:0] b,
                                          input logic ci);
    logic [16:0] w;
    logic [15:0] o;
    logic        co;
    logic        z;
    w  = 17'd0;
    o  = 16'd0;
    co = 1'b0;
    case (op)
      0: o = b;
      1: o = a & b;
      2: o = a | b;
      3: o = ~b;
      4: begin o = {b[14:0], 1'b0}; co = b[15]; end
      5: begin o = {1'b0, b[15:1]}; co = b[0]; end
      6: begin w = {1'b0, a} + {1'b0, b} + {16'd0, ci}; o = w[15:0]; co = w[16]; end
      7: begin w = {1'b0, a} - {1'b0, b} - {16'd0, ci}; o = w[15:0]; co = w[16]; end
      8: o = {8'd0, a[7:0]} * {8'd0, b[7:0]};
      9: begin o = a; co = (a > b); end
      default: o = 16'd0;
    endcase
    z = (op == 9) ? (a == b) : (o == 16'd0);
    return {co, z, o};
  endfunction

  // ALU driven from the DUT's select lines; a non-one-hot select gives a poison value.
  always_comb begin
    logic [17:0] r;
    int          idx;
    idx = 15;
    r   = 18'd0;
    for (int i = 0; i < 10; i++) begin
      if (sel[i]) idx = i;
    end
    if (sel == 10'd0) r = alu_ref(15, opA, opB, cin);
    else if ($onehot(sel)) r = alu_ref(idx, opA, opB, cin);
    else r = {2'b00, 16'hDEAD};
    {cout, zout, aluout} = r;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Reference model of the sequencer's architectural effect for one request.
  task automatic predict(input logic [3:0] op, input logic uc, input logic [15:0] a,
                         input logic [15:0] b, output exp_t e);
    logic [17:0] r;
    e.op     = op;
    e.cin    = uc & m_c;
    e.ill    = 1'b0;
    e.onehot = 10'd0;
    e.selc   = 0;
    e.lat    = S + 2;
    e.res    = 16'd0;
    if (op < 4'd10) begin
      r        = alu_ref(int'(op), a, b, e.cin);
      e.res    = r[15:0];
      m_z      = r[16];
      if (op == 4'd6 || op == 4'd7 || op == 4'd9) m_c = r[17];
      e.onehot = 10'd1 << op;
      e.selc   = S + 1;
    end else begin
`ifdef ALU_ILLEGAL_TRAP_EN
      e.ill = 1'b1;
      e.lat = 1;
`else
      m_z = 1'b1;
`endif
    end
    e.c = m_c;
    e.z = m_z;
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each result handshake.
  bit          busy = 1'b0;
  bit          rv_seen, bad_sel, bad_cin;
  int          cyc = 0;
  int          acc_cyc, selc;
  logic [17:0] held;
  exp_t        cur;

  always @(negedge clk) begin
    cyc++;
    if (!mon_en) begin
      busy = 1'b0;
    end else if (!busy) begin
      chk("idle_sel_cin", {21'd0, sel, cin}, 32'd0);
      if (op_valid && op_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_accept: opcode %0h accepted with empty scoreboard", opcode);
        end else begin
          cur     = q[0];
          busy    = 1'b1;
          acc_cyc = cyc;
          rv_seen = 1'b0;
          selc    = 0;
          bad_sel = 1'b0;
          bad_cin = 1'b0;
        end
      end
    end else begin
      chk("op_ready_busy", {31'd0, op_ready}, 32'd0);
      if (!res_valid) begin
        if (sel != 10'd0) begin
          selc++;
          if (sel != cur.onehot) bad_sel = 1'b1;
          if (cin !== cur.cin) bad_cin = 1'b1;
        end
      end else begin
        chk("result_sel_cin", {21'd0, sel, cin}, 32'd0);
        if (!rv_seen) begin
          rv_seen = 1'b1;
          held    = {result, c_flag, z_flag};
          chk("latency", cyc - acc_cyc, cur.lat);
          chk("sel_cycles", selc, cur.selc);
          chk("sel_onehot", {31'd0, bad_sel}, 32'd0);
          chk("cin", {31'd0, bad_cin}, 32'd0);
          chk("result", {16'd0, result}, {16'd0, cur.res});
          chk("c_flag", {31'd0, c_flag}, {31'd0, cur.c});
          chk("z_flag", {31'd0, z_flag}, {31'd0, cur.z});
`ifdef ALU_ILLEGAL_TRAP_EN
          chk("illegal_op", {31'd0, illegal_op}, {31'd0, cur.ill});
`endif
        end else begin
          chk("result_hold", {14'd0, result, c_flag, z_flag}, {14'd0, held});
        end
        if (res_ready) begin
          void'(q.pop_front());
          busy = 1'b0;
          done_cnt++;
        end
      end
    end
  end

  // Consumer: stalls the first stall_req result cycles, then random readiness.
  initial begin
    int cnt;
    bit prv;
    cnt       = 0;
    prv       = 1'b0;
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (res_valid && !prv) cnt = stall_req;
      prv = res_valid;
      if (res_valid && cnt > 0) begin
        res_ready = 1'b0;
        cnt--;
      end else begin
        res_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic do_op(input logic [3:0] op, input logic uc, input logic [15:0] a,
                       input logic [15:0] b, input int stall);
    exp_t e;
    int   d0;
    int   t;
    predict(op, uc, a, b, e);
    q.push_back(e);
    d0 = done_cnt;
    @(posedge clk);
    #1;
    opA       = a;
    opB       = b;
    opcode    = op;
    use_carry = uc;
    stall_req = stall;
    op_valid  = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (op_ready || t > 20) break;
      t++;
    end
    chk("accept_wait", {31'd0, t > 20}, 32'd0);
    @(posedge clk);
    #1;
    op_valid  = 1'b0;
    opcode    = 4'($urandom);
    use_carry = 1'($urandom);
    // Stray requests while busy must be ignored.
    t = 0;
    while (done_cnt == d0 && t < 300) begin
      op_valid = ($urandom_range(0, 2) == 0);
      opcode   = 4'($urandom);
      @(posedge clk);
      #1;
      t++;
    end
    op_valid = 1'b0;
    chk("done_wait", {31'd0, t >= 300}, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    op_valid  = 1'b0;
    opcode    = 4'd0;
    use_carry = 1'b0;
    opA       = 16'd0;
    opB       = 16'd0;
    m_c       = 1'b0;
    m_z       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_op_ready", {31'd0, op_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_sel_cin", {21'd0, sel, cin}, 32'd0);
    chk("rst_result_flags", {14'd0, result, c_flag, z_flag}, 32'd0);
`ifdef ALU_ILLEGAL_TRAP_EN
    chk("rst_illegal_op", {31'd0, illegal_op}, 32'd0);
`endif
    rst_n  = 1'b1;
    mon_en = 1'b1;

    do_op(4'd6, 1'b0, 16'hFFFF, 16'h0001, 0);
    do_op(4'd6, 1'b1, 16'hFFFF, 16'h0000, 0);
    do_op(4'd9, 1'b0, 16'h0005, 16'h0003, 0);
    do_op(4'd1, 1'b1, 16'h0005, 16'h0003, 0);
    do_op(4'd3, 1'b0, 16'h1234, 16'h00F0, 5);
    do_op(4'd8, 1'b0, 16'h0012, 16'h0034, 1);
    do_op(4'd12, 1'b1, 16'hAAAA, 16'h5555, 0);
    do_op(4'd7, 1'b1, 16'h0003, 16'h0003, 2);

    // Reset in the middle of an add
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    opA       = 16'h00FF;
    opB       = 16'h0F0F;
    opcode    = 4'd6;
    use_carry = 1'b1;
    op_valid  = 1'b1;
    @(negedge clk);
    chk("t1_ready", {31'd0, op_ready}, 32'd1);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t1_addb_issue", {31'd0, AaddB}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_sel_cin", {21'd0, sel, cin}, 32'd0);
    chk("t1_res_valid", {31'd0, res_valid}, 32'd0);
    chk("t1_result_flags", {14'd0, result, c_flag, z_flag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_op_ready", {31'd0, op_ready}, 32'd1);
    q.delete();
    m_c    = 1'b0;
    m_z    = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 60; i++) begin
      do_op(4'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom),
            ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom),
            $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
